// File: rtl/tm1638_pkg.sv
// tm1638_pkg: shared states, TM1638 command bytes and 27 MHz timing defaults.
package tm1638_pkg;
  typedef enum logic [2:0] {
    S_IDLE, S_STB_LO, S_CMD_L, S_WAIT, S_RDLY, S_DAT_L, S_END, S_GAP
  } state_t;
  localparam logic [7:0] C_WRITE = 8'h40;
  localparam logic [7:0] C_READ  = 8'h42;
  localparam logic [7:0] C_ADDR  = 8'hC0;
  localparam logic [7:0] C_DISP  = 8'h8F;
  localparam int GAP_CYC_27M     = 27;
  localparam int RD_WAIT_CYC_27M = 27;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick with a registered priority pointer.
module rr_arbiter #(
  parameter int N = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic         upd,
  input  logic [N-1:0] last,
  output logic [N-1:0] gnt
);
  localparam int PW = N > 1 ? $clog2(N) : 1;
  logic [PW-1:0] ptr, nxt;
  logic found;
  always_comb begin
    gnt = '0;
    found = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (!found && req[(int'(ptr) + k) % N]) begin
        gnt[(int'(ptr) + k) % N] = 1'b1;
        found = 1'b1;
      end
    end
  end
  // priority moves to the client after the one just served
  always_comb begin
    nxt = ptr;
    for (int i = 0; i < N; i++)
      if (last[i]) nxt = PW'((i + 1) % N);
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) ptr <= '0;
    else if (upd) ptr <= nxt;
endmodule

// File: rtl/tm1638_xfer_arbiter.sv
// tm1638_xfer_arbiter: shares one TM1638 byte engine and STB among NCLI clients,
// one STB-low frame (command + 0..MAXLEN data bytes) per grant.
module tm1638_xfer_arbiter import tm1638_pkg::*; #(
  parameter int NCLI        = 2,
  parameter int MAXLEN      = 16,
  parameter int GAP_CYC     = GAP_CYC_27M,
  parameter int RD_WAIT_CYC = RD_WAIT_CYC_27M,
  localparam int LW         = $clog2(MAXLEN + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NCLI-1:0]    req,
  input  logic [NCLI*8-1:0]  cli_cmd,
  input  logic [NCLI*LW-1:0] cli_len,
  input  logic [NCLI-1:0]    cli_rd,
  input  logic [NCLI*8-1:0]  cli_wdata,
  output logic [NCLI-1:0]    gnt,
  output logic [LW-1:0]      byte_idx,
  output logic               wr_adv,
  output logic               rd_valid,
  output logic [7:0]         rd_data,
  output logic [NCLI-1:0]    done,
  output logic               eng_latch,
  output logic [7:0]         eng_data,
  output logic               eng_rw,
  input  logic               eng_busy,
  input  logic [7:0]         eng_rdata,
  output logic               sio_stb
);
  localparam int CW = $clog2((GAP_CYC > RD_WAIT_CYC ? GAP_CYC : RD_WAIT_CYC) + 1);
  state_t state, state_n;
  logic [NCLI-1:0] sel_r, sel_n, arb_gnt;
  logic [7:0] cmd_r, cmd_n, win_cmd, wdata, rdd_n;
  logic [LW-1:0] len_r, len_n, win_len, idx_n;
  logic [CW-1:0] cnt, cnt_n;
  logic rd_r, rd_n, win_rd, dph_r, dph_n, lat_q, adv_r, adv_n, busy_fell;
  rr_arbiter #(.N(NCLI)) u_rr (
    .clk (clk),
    .rst (rst),
    .req (req),
    .upd (state == S_GAP),
    .last(sel_r),
    .gnt (arb_gnt)
  );
  always_comb begin
    win_cmd = '0;
    win_len = '0;
    win_rd = 1'b0;
    wdata = '0;
    for (int i = 0; i < NCLI; i++) begin
      if (arb_gnt[i]) begin
        win_cmd = cli_cmd[8*i +: 8];
        win_len = cli_len[LW*i +: LW];
        win_rd = cli_rd[i];
      end
      if (sel_r[i]) wdata = cli_wdata[8*i +: 8];
    end
  end
  // lat_q masks the first WAIT cycle, before the engine has raised busy
  assign busy_fell = state == S_WAIT && !lat_q && !eng_busy;
  always_comb begin
    state_n = state;
    sel_n = sel_r;
    cmd_n = cmd_r;
    len_n = len_r;
    rd_n = rd_r;
    dph_n = dph_r;
    adv_n = 1'b0;
    rdd_n = rd_data;
    idx_n = state == S_END ? '0 : byte_idx + LW'(adv_r);
    cnt_n = (state == S_RDLY || state == S_GAP) ? cnt + CW'(1) : '0;
    case (state)
      S_IDLE: if (|req) begin
        state_n = S_STB_LO;
        sel_n = arb_gnt;
        cmd_n = win_cmd;
        len_n = win_len > LW'(MAXLEN) ? LW'(MAXLEN) : win_len;
        rd_n = win_rd;
        dph_n = 1'b0;
      end
      S_STB_LO: state_n = S_CMD_L;
      S_CMD_L, S_DAT_L: state_n = S_WAIT;
      S_WAIT: if (busy_fell) begin
        if (!dph_r) begin
          dph_n = 1'b1;
          state_n = len_r == '0 ? S_END : rd_r ? S_RDLY : S_DAT_L;
        end else begin
          adv_n = 1'b1;
          rdd_n = rd_r ? eng_rdata : rd_data;
          state_n = byte_idx + LW'(1) == len_r ? S_END : S_DAT_L;
        end
      end
      S_RDLY: state_n = cnt == CW'(RD_WAIT_CYC - 1) ? S_DAT_L : S_RDLY;
      S_END: state_n = S_GAP;
      S_GAP: state_n = cnt == CW'(GAP_CYC - 1) ? S_IDLE : S_GAP;
      default: state_n = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= S_IDLE;
      sel_r <= '0;
      cmd_r <= '0;
      len_r <= '0;
      rd_r <= 1'b0;
      dph_r <= 1'b0;
      lat_q <= 1'b0;
      adv_r <= 1'b0;
      byte_idx <= '0;
      cnt <= '0;
      rd_data <= '0;
    end else begin
      state <= state_n;
      sel_r <= sel_n;
      cmd_r <= cmd_n;
      len_r <= len_n;
      rd_r <= rd_n;
      dph_r <= dph_n;
      lat_q <= eng_latch;
      adv_r <= adv_n;
      byte_idx <= idx_n;
      cnt <= cnt_n;
      rd_data <= rdd_n;
    end
  assign sio_stb   = state inside {S_IDLE, S_END, S_GAP};
  assign gnt       = sio_stb ? '0 : sel_r;
  assign done      = state == S_END ? sel_r : '0;
  assign eng_latch = state inside {S_CMD_L, S_DAT_L};
  assign eng_data  = state == S_CMD_L ? cmd_r : (state == S_DAT_L && !rd_r) ? wdata : 8'h00;
  assign eng_rw    = !(rd_r && dph_r && state inside {S_RDLY, S_DAT_L, S_WAIT});
  // wr_adv fires while still in WAIT so the client's next byte settles before DAT_L
  assign wr_adv    = busy_fell && dph_r && !rd_r;
  assign rd_valid  = adv_r && rd_r;
endmodule

// File: tb/tb_tm1638_xfer_arbiter.sv
// tb_tm1638_xfer_arbiter: scoreboard bench with a 3-cycle byte engine model.
module tb_tm1638_xfer_arbiter;
  localparam int LW = 5;
  logic clk = 1'b0, rst = 1'b1;
  logic [1:0] req = '0, cli_rd = '0;
  logic [15:0] cli_cmd = '0, cli_wdata;
  logic [9:0] cli_len = '0;
  logic [1:0] gnt, done;
  logic [LW-1:0] byte_idx;
  logic wr_adv, rd_valid, eng_latch, eng_rw, sio_stb, eng_busy;
  logic [7:0] rd_data, eng_data, eng_rdata = '0;
  int bcnt = 0, rd_i = 0, cyc = 0;
  logic [7:0] wd [2] = '{8'h50, 8'h00};
  logic [7:0] rd_tab [16];
  typedef struct packed {logic [7:0] d; logic rw;} lat_t;
  lat_t latq[$];
  logic [12:0] rdq[$];
  int gntq[$], doneq[$];
  string dname[$];
  logic [31:0] dact[$], dexp[$];
  int n_cmp = 0, n_fail = 0, wr_cnt = 0, hi_cnt = 1000, latch_no = 0, t_cmd = 0, t_d0 = 0;
  logic [1:0] prev_gnt = '0;
  logic prev_stb = 1'b1;

  tm1638_xfer_arbiter #(.NCLI(2), .MAXLEN(16), .GAP_CYC(27), .RD_WAIT_CYC(27)) dut (
    .clk(clk), .rst(rst), .req(req), .cli_cmd(cli_cmd), .cli_len(cli_len),
    .cli_rd(cli_rd), .cli_wdata(cli_wdata), .gnt(gnt), .byte_idx(byte_idx),
    .wr_adv(wr_adv), .rd_valid(rd_valid), .rd_data(rd_data), .done(done),
    .eng_latch(eng_latch), .eng_data(eng_data), .eng_rw(eng_rw),
    .eng_busy(eng_busy), .eng_rdata(eng_rdata), .sio_stb(sio_stb)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  assign eng_busy = bcnt != 0;
  assign cli_wdata = {wd[1], wd[0]};

  always @(posedge clk)
    if (rst) bcnt <= 0;
    else if (eng_latch) begin
      bcnt <= 3;
      if (!eng_rw) begin
        eng_rdata <= rd_tab[rd_i];
        rd_i <= rd_i + 1;
      end
    end else if (bcnt != 0) bcnt <= bcnt - 1;

  always @(posedge clk)
    if (wr_adv) begin
      if (gnt[0]) wd[0] <= wd[0] + 8'd1;
      if (gnt[1]) wd[1] <= wd[1] + 8'd1;
    end

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    n_cmp++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask

  always @(negedge clk) begin
    lat_t e;
    while (dname.size() != 0) chk(dname.pop_front(), dact.pop_front(), dexp.pop_front());
    if (rst) begin
      hi_cnt = 1000;
      prev_gnt = '0;
      prev_stb = 1'b1;
    end else begin
      if (gnt != prev_gnt) begin
        chk("gnt_onehot", 32'($onehot0(gnt)), 1);
        if (prev_gnt == '0) begin
          latch_no = 0;
          if (gntq.size() == 0) chk("gnt_extra", 32'(gnt), 0);
          else chk("gnt_order", 32'(gnt), 32'd1 << gntq.pop_front());
        end
      end
      if (eng_latch) begin
        if (latq.size() == 0) chk("latch_extra", 1, 0);
        else begin
          e = latq.pop_front();
          chk("latch_data_rw", 32'({eng_data, eng_rw}), 32'(e));
        end
        if (latch_no == 0) t_cmd = cyc;
        if (latch_no == 1) t_d0 = cyc;
        latch_no++;
      end
      if (rd_valid) begin
        if (rdq.size() == 0) chk("rd_extra", 1, 0);
        else chk("rd_idx_data", 32'({byte_idx, rd_data}), 32'(rdq.pop_front()));
      end
      if (done != '0) begin
        if (doneq.size() == 0) chk("done_extra", 32'(done), 0);
        else chk("done_client", 32'(done), 32'd1 << doneq.pop_front());
        chk("done_stb_rw", 32'({sio_stb, eng_rw}), 32'b11);
      end
      if (wr_adv) wr_cnt++;
      if (sio_stb) hi_cnt++;
      else begin
        if (prev_stb) chk("stb_gap_ge27", 32'(hi_cnt >= 27), 1);
        hi_cnt = 0;
      end
      prev_gnt = gnt;
      prev_stb = sio_stb;
    end
  end

  task automatic dchk(input string n, input logic [31:0] a, input logic [31:0] e);
    dname.push_back(n);
    dact.push_back(a);
    dexp.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_gnt(input int c);
    int k = 0;
    while (!gnt[c] && k < 500) begin
      tick();
      k++;
    end
    if (!gnt[c]) dchk("timeout_gnt", 0, 1);
  endtask

  task automatic wait_done(input logic [1:0] m);
    int k = 0;
    do begin
      @(negedge clk);
      k++;
    end while ((done & m) == '0 && k < 3000);
    if ((done & m) == '0) dchk("timeout_done", 0, 1);
  endtask

  task automatic frame(input int c, input logic [7:0] cmd, input logic [4:0] len, input logic rd);
    cli_cmd[8*c +: 8] = cmd;
    cli_len[5*c +: 5] = len;
    cli_rd[c] = rd;
    gntq.push_back(c);
    doneq.push_back(c);
    req[c] = 1'b1;
    wait_gnt(c);
    req[c] = 1'b0;
    wait_done(2'(1 << c));
  endtask

  initial begin
    int w0, k;
    for (int i = 0; i < 16; i++) rd_tab[i] = i < 4 ? 8'((i + 1) * 17) : 8'(8'h60 + i - 4);
    repeat (3) tick();
    dchk("reset_outputs", 32'({sio_stb, eng_rw, gnt, done, eng_latch, wr_adv, rd_valid, byte_idx, rd_data, eng_data}),
         32'({2'b11, 28'd0}));
    rst = 1'b0;
    repeat (5) tick();
    // zero-length write
    latq.push_back({8'h40, 1'b1});
    frame(0, 8'h40, 5'd0, 1'b0);
    // 4-byte read
    latq.push_back({8'h42, 1'b1});
    for (int i = 0; i < 4; i++) begin
      latq.push_back({8'h00, 1'b0});
      rdq.push_back({5'(i), rd_tab[i]});
    end
    frame(0, 8'h42, 5'd4, 1'b1);
    dchk("rd_wait_ge28", 32'((t_d0 - t_cmd) >= 28), 1);
    // full-length write
    w0 = wr_cnt;
    latq.push_back({8'hC0, 1'b1});
    for (int i = 0; i < 16; i++) latq.push_back({8'(i), 1'b1});
    frame(1, 8'hC0, 5'd16, 1'b0);
    dchk("wr_adv_16", 32'(wr_cnt - w0), 16);
    // contention
    cli_cmd = {8'h44, 8'h40};
    cli_len = '0;
    cli_rd = '0;
    for (int i = 0; i < 4; i++) begin
      latq.push_back({i % 2 == 1 ? 8'h44 : 8'h40, 1'b1});
      gntq.push_back(i % 2);
      doneq.push_back(i % 2);
    end
    req = 2'b11;
    for (int i = 0; i < 4; i++) wait_done(2'b11);
    req = 2'b00;
    // len clamp
    w0 = wr_cnt;
    latq.push_back({8'hC0, 1'b1});
    for (int i = 0; i < 16; i++) latq.push_back({8'(8'h50 + i), 1'b1});
    frame(0, 8'hC0, 5'd20, 1'b0);
    dchk("clamp_16", 32'(wr_cnt - w0), 16);
    // reset during read byte 5
    cli_cmd[7:0] = 8'h42;
    cli_len[4:0] = 5'd10;
    cli_rd[0] = 1'b1;
    gntq.push_back(0);
    latq.push_back({8'h42, 1'b1});
    for (int i = 0; i < 6; i++) latq.push_back({8'h00, 1'b0});
    for (int i = 0; i < 5; i++) rdq.push_back({5'(i), rd_tab[4 + i]});
    req[0] = 1'b1;
    wait_gnt(0);
    req[0] = 1'b0;
    k = 0;
    while (!(byte_idx == 5 && eng_busy) && k < 1000) begin
      tick();
      k++;
    end
    if (k == 1000) dchk("timeout_byte5", 0, 1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    dchk("mid_reset", 32'({sio_stb, gnt, eng_rw, done}), 32'b1_00_1_00);
    repeat (4) tick();
    rst = 1'b0;
    repeat (40) tick();
    dchk("queues_drained", 32'(latq.size() + rdq.size() + gntq.size() + doneq.size()), 0);
    repeat (3) @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
